// File: rtl/key_event.sv
// key_event: turns a debounced button level into PRESS / RELEASE / LONG /
// REPEAT events delivered through a single valid/ready output register.
// A dropped event (output busy and not accepted) sets a sticky overflow flag.
//
// Build option: define KEY_EVENT_REPEAT_EN to emit REPEAT events every
// REPEAT_CYCLES while the button stays held after a LONG event. Without it
// the LONG state only waits for release and code 11 is never produced.
module key_event #(
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned REPEAT_CYCLES     = 10000000,
    parameter int unsigned CNT_W             = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       button_i,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [1:0] evt_code_o,
    output logic       pressed_o,
    output logic       overflow_o,
    input  logic       ovf_clr_i
);

    // Thresholds must fit the hold counter (values >= 2**32 cannot be
    // expressed by the parameter type, so wide counters always fit).
    localparam bit LONG_FITS = (CNT_W >= 32) ||
                               (64'(LONG_PRESS_CYCLES) < (64'd1 << CNT_W));
    localparam bit REP_FITS  = (CNT_W >= 32) ||
                               (64'(REPEAT_CYCLES) < (64'd1 << CNT_W));

    generate
        if (CNT_W < 1 || LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 2 ||
            !LONG_FITS || !REP_FITS) begin : g_bad_params
            $error("key_event: illegal LONG_PRESS_CYCLES/REPEAT_CYCLES/CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } state_e;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_valid_q, evt_valid_d;
    evt_e             evt_code_q, evt_code_d;
    logic             ovf_q, ovf_d;

    // Event produced by this cycle's transition, before the output handshake
    logic             new_evt;
    evt_e             new_code;

    // State, counter and output register; reset forces everything idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= EVT_PRESS;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next state, hold counter and the event each transition generates;
    // release is tested first so it wins over a coincident threshold match
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_evt  = 1'b0;
        new_code = EVT_PRESS;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (button_i) begin
                    state_d  = ST_HELD;
                    new_evt  = 1'b1;
                    new_code = EVT_PRESS;
                end
            end
            ST_HELD: begin
                if (!button_i) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    new_evt  = 1'b1;
                    new_code = EVT_RELEASE;
                end else if (cnt_q == LONG_LAST) begin
                    state_d  = ST_LONG;
                    cnt_d    = '0;
                    new_evt  = 1'b1;
                    new_code = EVT_LONG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LONG: begin
                if (!button_i) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    new_evt  = 1'b1;
                    new_code = EVT_RELEASE;
                end else begin
`ifdef KEY_EVENT_REPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        cnt_d    = '0;
                        new_evt  = 1'b1;
                        new_code = EVT_REPEAT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output register handshake and sticky overflow flag
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        ovf_d       = ovf_q;
        if (new_evt && (!evt_valid_q || evt_ready_i)) begin
            evt_valid_d = 1'b1;
            evt_code_d  = new_code;
        end else if (evt_valid_q && evt_ready_i) begin
            evt_valid_d = 1'b0;
        end
        if (new_evt && evt_valid_q && !evt_ready_i) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_code_o  = evt_code_q;
    assign pressed_o   = (state_q != ST_IDLE);
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: a press-duration model predicts every output each
// cycle; directed scenarios pin the model with literal expectations, then
// randomized button/ready/clear traffic runs against the model.
module tb_key_event;

    localparam int LP  = 8;
    localparam int RP  = 4;
    localparam int CW  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button = 1'b0;
    logic       ready = 1'b1;
    logic       ovf_clr = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       pressed;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    key_event #(
        .LONG_PRESS_CYCLES(LP),
        .REPEAT_CYCLES(RP),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .button_i(button),
        .evt_valid_o(evt_valid),
        .evt_ready_i(ready),
        .evt_code_o(evt_code),
        .pressed_o(pressed),
        .overflow_o(overflow),
        .ovf_clr_i(ovf_clr)
    );

    always #5 clk = ~clk;

    // Model: m_hold counts sampled-high edges since the press edge
    logic       m_pressed;
    int         m_hold;
    logic       m_valid;
    logic [1:0] m_code;
    logic       m_ovf;
    logic [1:0] dut_xfer_q[$];

    always @(posedge clk or negedge rst_n) begin : model
        logic       g;
        logic [1:0] c;
        int         h;
        if (!rst_n) begin
            m_pressed <= 1'b0;
            m_hold    <= 0;
            m_valid   <= 1'b0;
            m_code    <= 2'b00;
            m_ovf     <= 1'b0;
        end else begin
            g = 1'b0;
            c = 2'b00;
            if (!m_pressed) begin
                if (button) begin
                    g = 1'b1; c = 2'b00;
                    m_pressed <= 1'b1;
                    m_hold    <= 0;
                end
            end else if (!button) begin
                g = 1'b1; c = 2'b01;
                m_pressed <= 1'b0;
                m_hold    <= 0;
            end else begin
                h = m_hold + 1;
                m_hold <= h;
                if (h == LP) begin
                    g = 1'b1; c = 2'b10;
                end
`ifdef KEY_EVENT_REPEAT_EN
                else if (h > LP && ((h - LP) % RP) == 0) begin
                    g = 1'b1; c = 2'b11;
                end
`endif
            end
            if (g && (!m_valid || ready)) begin
                m_valid <= 1'b1;
                m_code  <= c;
            end else if (m_valid && ready) begin
                m_valid <= 1'b0;
            end
            if (g && m_valid && !ready) m_ovf <= 1'b1;
            else if (ovf_clr)          m_ovf <= 1'b0;
        end
    end

    // Log of events the DUT actually handed over
    always @(posedge clk) begin
        if (rst_n && evt_valid && ready) dut_xfer_q.push_back(evt_code);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_valid", int'(evt_valid), int'(m_valid));
            if (m_valid) chk("cyc_code", int'(evt_code), int'(m_code));
            chk("cyc_pressed", int'(pressed), int'(m_pressed));
            chk("cyc_overflow", int'(overflow), int'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_out(input int n);
        button = 1'b0;
        ready  = 1'b1;
        ovf_clr = 1'b0;
        repeat (n) tick();
    endtask

    initial begin : stim
        logic [1:0] exp_list[$];
        int         run;

        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_code", int'(evt_code), 0);
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // Short press: PRESS one cycle after the press sample, RELEASE likewise
        button = 1'b1;
        tick();
        chk("s1_press_valid", int'(evt_valid), 1);
        chk("s1_press_code", int'(evt_code), 0);
        chk("s1_pressed", int'(pressed), 1);
        tick(); tick();
        button = 1'b0;
        tick();
        chk("s1_rel_valid", int'(evt_valid), 1);
        chk("s1_rel_code", int'(evt_code), 1);
        chk("s1_rel_pressed", int'(pressed), 0);
        tick();
        chk("s1_drain_valid", int'(evt_valid), 0);
        chk("s1_overflow", int'(overflow), 0);
        idle_out(2);

        // Long hold: 21 sampled-high edges then release
        dut_xfer_q.delete();
        button = 1'b1;
        repeat (21) tick();
        button = 1'b0;
        repeat (3) tick();
`ifdef KEY_EVENT_REPEAT_EN
        exp_list = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
`else
        exp_list = '{2'b00, 2'b10, 2'b01};
`endif
        chk("s2_count", dut_xfer_q.size(), exp_list.size());
        for (int i = 0; i < exp_list.size() && i < dut_xfer_q.size(); i++)
            chk("s2_event", int'(dut_xfer_q[i]), int'(exp_list[i]));
        idle_out(2);

        // Stalled consumer: RELEASE dropped, overflow set, then cleared
        ready  = 1'b0;
        button = 1'b1;
        tick();
        button = 1'b0;
        tick();
        chk("s3_held_valid", int'(evt_valid), 1);
        chk("s3_held_code", int'(evt_code), 0);
        chk("s3_overflow", int'(overflow), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("s3_ovf_cleared", int'(overflow), 0);
        chk("s3_still_code", int'(evt_code), 0);
        ready = 1'b1;
        tick();
        chk("s3_drained", int'(evt_valid), 0);
        idle_out(2);

        // Release exactly when the counter reaches LP-1: RELEASE, no LONG
        dut_xfer_q.delete();
        button = 1'b1;
        repeat (LP) tick();
        button = 1'b0;
        tick();
        chk("s4_rel_code", int'(evt_code), 1);
        repeat (2) tick();
        chk("s4_count", dut_xfer_q.size(), 2);
        if (dut_xfer_q.size() == 2) chk("s4_second", int'(dut_xfer_q[1]), 1);
        idle_out(2);

        // Reset mid-hold with an event pending, button still held afterwards
        ready  = 1'b0;
        button = 1'b1;
        repeat (3) tick();
        chk("s5_pending", int'(evt_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", int'(evt_valid), 0);
        chk("s5_rst_code", int'(evt_code), 0);
        chk("s5_rst_pressed", int'(pressed), 0);
        chk("s5_rst_overflow", int'(overflow), 0);
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        chk("s5_repress_valid", int'(evt_valid), 1);
        chk("s5_repress_code", int'(evt_code), 0);
        idle_out(3);

        // Repeat stream with ready toggling every cycle
        button = 1'b1;
        ready  = 1'b0;
        repeat (30) begin
            tick();
            ready = ~ready;
        end
        button = 1'b0;
        idle_out(4);

        // Randomized traffic: hold runs of varying length, random back-pressure
        for (int i = 0; i < 300; i++) begin
            run = $urandom_range(1, 3 * LP);
            button = ~button;
            repeat (run) begin
                ready   = ($urandom_range(0, 3) != 0);
                ovf_clr = ($urandom_range(0, 19) == 0);
                tick();
            end
        end
        idle_out(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter LONG_PRESS_CYCLES, default 50000000: cycles held after press before a LONG event.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 10000000: interval between REPEAT events after LONG.
REQ-003 SHALL have parameter CNT_W, default 32: hold-counter width.
REQ-004 SHALL have port clk_i, input, 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port button_i, input, 1: debounced level from the debounce block, 1 = pressed, synchronous to clk_i.
REQ-007 SHALL have port evt_valid_o, output, 1: event available.
REQ-008 SHALL have port evt_ready_i, input, 1: consumer accepts the event.
REQ-009 SHALL have port evt_code_o, output, 2: event code, 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT.
REQ-010 SHALL have port pressed_o, output, 1: high whenever the state is not IDLE.
REQ-011 SHALL have port overflow_o, output, 1: sticky flag, an event was dropped.
REQ-012 SHALL have port ovf_clr_i, input, 1: synchronous clear of overflow_o.

Function
REQ-013 SHALL implement FSM states IDLE, HELD and LONG, plus one CNT_W-bit hold counter.
REQ-014 IDLE with button_i=1 SHALL go to HELD, clear the counter and generate PRESS.
REQ-015 HELD with button_i=0 SHALL go to IDLE and generate RELEASE.
REQ-016 HELD with button_i=1 and counter = LONG_PRESS_CYCLES-1 SHALL go to LONG, clear the counter and generate LONG; otherwise it SHALL increment the counter.
REQ-017 LONG with button_i=0 SHALL go to IDLE and generate RELEASE.
REQ-018 When button_i=0 coincides with a threshold match, RELEASE SHALL win and no LONG/REPEAT SHALL be generated.
REQ-019 Each generated event SHALL appear on evt_valid_o/evt_code_o in the cycle after the edge that sampled the causing button_i value (latency 1).
REQ-020 Output register handshake: the event is held stable while evt_valid_o=1 and evt_ready_i=0; transfer occurs on the edge where both are 1.
REQ-021 A new event SHALL load when evt_valid_o=0 or a transfer occurs on the same edge; evt_valid_o stays 1 back-to-back.
REQ-022 A new event arriving while evt_valid_o=1 and evt_ready_i=0 SHALL be dropped, the held event kept, and overflow_o set.
REQ-023 With no new event and a transfer, evt_valid_o SHALL go 0 on the next cycle.
REQ-024 overflow_o SHALL clear on ovf_clr_i=1; a simultaneous drop SHALL take priority (flag stays 1).
REQ-025 The counter SHALL never wrap; it SHALL be cleared on every state change.
REQ-026 Legal parameters: LONG_PRESS_CYCLES>=2 and REPEAT_CYCLES>=2, both < 2**CNT_W; elaboration SHALL fail otherwise.

Reset
REQ-027 rst_ni=0 SHALL immediately force state IDLE, counter 0, evt_valid_o 0, evt_code_o 00, pressed_o 0, overflow_o 0.
REQ-028 Reset mid-press SHALL discard any pending event; if button_i=1 at the first edge after release, PRESS SHALL be generated per REQ-014.

Configuration
REQ-029 Macro KEY_EVENT_REPEAT_EN defined: in LONG with button_i=1, when counter = REPEAT_CYCLES-1, SHALL generate REPEAT and clear the counter; otherwise it SHALL increment the counter.
REQ-030 Macro KEY_EVENT_REPEAT_EN undefined: LONG SHALL only wait for release, the counter SHALL hold 0, and code 11 SHALL never be emitted.

Verification (LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4, evt_ready_i=1 unless noted)
REQ-031 Press held 3 cycles then released -> PRESS one cycle after the press sample, RELEASE one cycle after the release sample, overflow_o=0.
REQ-032 Press held 20 cycles with REPEAT_EN -> PRESS, then LONG 8 cycles later, then REPEAT every 4 cycles (3 REPEATs), then RELEASE; without REPEAT_EN -> PRESS, LONG, RELEASE only.
REQ-033 evt_ready_i=0, press then release -> PRESS held, RELEASE dropped, overflow_o=1; ovf_clr_i pulse -> overflow_o=0.
REQ-034 Release on the exact cycle counter=7 in HELD -> RELEASE emitted, no LONG.
REQ-035 rst_ni low mid-hold with evt_valid_o=1 -> all outputs 0 asynchronously; button_i still 1 after reset release -> PRESS.
REQ-036 evt_ready_i toggled every cycle during REPEAT stream -> every accepted event is stable until transfer, with no duplicates.
